// File: rtl/ps2_key_event_ctrl_if.sv
// Key-event controller bus: PS/2 byte strobe in, key-event valid/ready out,
// plus FIFO occupancy and sticky overflow status.
interface ps2_key_event_ctrl_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                        rx_valid;
    logic [7:0]                  rx_code;
    logic                        evt_valid;
    logic                        evt_ready;
    logic [7:0]                  evt_code;
    logic                        evt_break;
    logic                        evt_ext;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic                        overflow_clr;

    modport master (
        output rx_valid, rx_code, evt_ready, overflow_clr,
        input  evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow
    );

    modport slave (
        input  rx_valid, rx_code, evt_ready, overflow_clr,
        output evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code-set-2 prefix decoder feeding a show-ahead event FIFO.
// Optional typematic repeat filter: define PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_key_event_ctrl_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [TW-1:0]  tmo_r, tmo_nxt_s;
    logic [2:0]     skip_r, skip_nxt_s;
    logic           evt_s, brk_s, ext_s, push_s;
    logic [7:0]     code_s;

    logic [9:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]  count_r, count_nxt_s;
    logic           valid_r, overflow_r;
    logic [9:0]     head_r, head_nxt_s, wdata_s;
    logic           pop_s, full_s, wr_s, drop_s;

    // Decoder state, prefix timeout and pause-sequence skip counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            tmo_r   <= '0;
            skip_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            tmo_r   <= tmo_nxt_s;
            skip_r  <= skip_nxt_s;
        end
    end

    // Prefix decoding: next state and the candidate event for this byte.
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = '0;
        skip_nxt_s  = skip_r;
        evt_s       = 1'b0;
        code_s      = bus.rx_code;
        brk_s       = 1'b0;
        ext_s       = 1'b0;
        if (bus.rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    case (bus.rx_code)
                        8'hE0: state_nxt_s = S_EXT;
                        8'hF0: state_nxt_s = S_BRK;
                        8'hE1: begin
                            state_nxt_s = S_SKIP;
                            skip_nxt_s  = 3'd7;
                        end
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt_s = S_IDLE;
                        default: evt_s = 1'b1;
                    endcase
                end
                S_EXT: begin
                    case (bus.rx_code)
                        8'hF0:   state_nxt_s = S_EXT_BRK;
                        8'hE0:   state_nxt_s = S_EXT;
                        default: begin
                            evt_s       = 1'b1;
                            ext_s       = 1'b1;
                            state_nxt_s = S_IDLE;
                        end
                    endcase
                end
                S_BRK, S_EXT_BRK: begin
                    state_nxt_s = S_IDLE;
                    if (bus.rx_code == 8'hE0 || bus.rx_code == 8'hF0) begin
                        evt_s = 1'b0;
                    end else begin
                        evt_s = 1'b1;
                        brk_s = 1'b1;
                        ext_s = (state_r == S_EXT_BRK);
                    end
                end
                S_SKIP: begin
                    if (skip_r == 3'd1) begin
                        evt_s       = 1'b1;
                        code_s      = 8'h77;
                        ext_s       = 1'b1;
                        skip_nxt_s  = 3'd0;
                        state_nxt_s = S_IDLE;
                    end else begin
                        skip_nxt_s = skip_r - 3'd1;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end else if (state_r != S_IDLE) begin
            // A byte arriving on the expiry cycle wins, so expiry is only checked here.
            if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
                state_nxt_s = S_IDLE;
                skip_nxt_s  = 3'd0;
            end else begin
                tmo_nxt_s = tmo_r + TW'(1);
            end
        end else begin
            tmo_nxt_s = '0;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [255:0] keydown_r;
    logic [7:0]   key_idx_s;
    logic         pause_s;

    assign key_idx_s = {ext_s, code_s[6:0]};
    assign pause_s   = (state_r == S_SKIP);
    assign push_s    = evt_s && !(!brk_s && !pause_s && keydown_r[key_idx_s]);

    // Key-down bitmap: makes set, breaks clear; the pause key is not tracked.
    always_ff @(posedge clk) begin
        if (reset) begin
            keydown_r <= '0;
        end else if (evt_s && !pause_s) begin
            keydown_r[key_idx_s] <= !brk_s;
        end
    end
`else
    assign push_s = evt_s;
`endif

    // FIFO control: accepted push/pop, occupancy and the next registered head.
    always_comb begin
        pop_s      = valid_r && bus.evt_ready;
        full_s     = (count_r == CW'(FIFO_DEPTH));
        wr_s       = push_s && (!full_s || pop_s);
        drop_s     = push_s && full_s && !pop_s;
        wdata_s    = {code_s, brk_s, ext_s};
        head_nxt_s = head_r;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            if (count_r == CW'(1)) begin
                head_nxt_s = wr_s ? wdata_s : head_r;
            end else begin
                head_nxt_s = mem_r[rd_ptr_r + AW'(1)];
            end
        end else if (count_r == CW'(0) && wr_s) begin
            head_nxt_s = wdata_s;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // FIFO pointers, count, registered head/valid and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            head_r     <= 10'd0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != CW'(0));
            head_r  <= head_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Event storage; contents are meaningless until covered by the count.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    assign bus.evt_valid  = valid_r;
    assign bus.evt_code   = head_r[9:2];
    assign bus.evt_break  = head_r[1];
    assign bus.evt_ext    = head_r[0];
    assign bus.fifo_count = count_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: expected events are queued when
// bytes are sent and a negedge monitor compares every popped event.
module tb_ps2_key_event_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [9:0] sb [$];

    ps2_key_event_ctrl_if #(.FIFO_DEPTH(8)) bus ();

    ps2_key_event_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(50000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a pop happens at the next edge when valid & ready.
    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            act = {bus.evt_code, bus.evt_break, bus.evt_ext};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_evt got=%h (code,brk,ext) want=none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL evt got=%h want=%h", act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_code  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_evt(input logic [7:0] c, input logic brk, input logic ext);
        sb.push_back({c, brk, ext});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (bus.fifo_count == 0 && sb.size() == 0) break;
            idle(1);
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic pulse_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        bus.rx_valid     = 1'b0;
        bus.rx_code      = 8'h00;
        bus.evt_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        idle(3);
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_fields", {bus.evt_code, bus.evt_break, bus.evt_ext}, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset = 1'b0;
        idle(1);

        // Single make code and its one-cycle latency.
        bus.evt_ready = 1'b1;
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        chk("lat_valid", bus.evt_valid, 1);
        idle(1);
        chk("one_cycle_valid", bus.evt_valid, 0);

        expect_evt(8'h75, 1'b1, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_evt(8'h1C, 1'b1, 1'b0);
        send(8'hF0); send(8'h1C);
        drain("drain_basic");

        // Keyboard responses produce nothing.
        bus.evt_ready = 1'b0;
        send(8'hFA); send(8'hAA);
        idle(2);
        chk("proto_drop", bus.fifo_count, 0);
        bus.evt_ready = 1'b1;

        // Stale E0 discarded by timeout; a fresh E0 within the window still applies.
        send(8'hE0);
        idle(60000);
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        expect_evt(8'h1C, 1'b0, 1'b1);
        send(8'hE0);
        idle(100);
        send(8'h1C);
        drain("drain_timeout");

        // Pause sequence collapses to one event.
        expect_evt(8'h77, 1'b0, 1'b1);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain("drain_pause");

        // Reset mid-sequence drops the prefix.
        send(8'hE0);
        pulse_reset();
        expect_evt(8'h1C, 1'b1, 1'b0);
        send(8'hF0); send(8'h1C);
        drain("drain_reset");

        // Overflow: nine makes into an eight-deep FIFO.
        pulse_reset();
        bus.evt_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) expect_evt(8'(i), 1'b0, 1'b0);
            send(8'(i));
        end
        chk("full_count", bus.fifo_count, 8);
        chk("full_overflow", bus.overflow, 1);
        chk("full_head", bus.evt_code, 8'h01);
        idle(3);
        chk("head_hold", {bus.evt_valid, bus.evt_code}, {1'b1, 8'h01});
        bus.evt_ready = 1'b1;
        drain("drain_overflow");
        chk("overflow_sticky", bus.overflow, 1);
        bus.overflow_clr = 1'b1;
        idle(1);
        bus.overflow_clr = 1'b0;
        chk("overflow_clr", bus.overflow, 0);

        // Typematic repeats.
        pulse_reset();
        expect_evt(8'h1C, 1'b0, 1'b0);
`ifndef PS2_TYPEMATIC_FILTER_EN
        expect_evt(8'h1C, 1'b0, 1'b0);
        expect_evt(8'h1C, 1'b0, 1'b0);
`endif
        expect_evt(8'h1C, 1'b1, 1'b0);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain("drain_typematic");

        idle(5);
        chk("final_empty", bus.fifo_count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits directly downstream of the PS/2 byte receiver and consumes its one-cycle byte strobe and scan code.
- Runs the scan-code-set-2 prefix state machine (E0 extended, F0 break, E1 pause sequence) and turns byte sequences into single key events.
- Queues the events in a small FIFO and hands them to game/UI logic over a valid/ready handshake.
- Also drops keyboard protocol responses and stale prefixes.

Parameters:
- FIFO_DEPTH, 8, number of event entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles a partial prefix sequence may wait for its next byte (1 ms at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_code holds a new byte
- rx_code  input  8  received scan-code byte
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts the head event this cycle
- evt_code  output  8  key code of the head event
- evt_break  output  1  1 = key released, 0 = key pressed
- evt_ext  output  1  1 = E0-extended key
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued events
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  input  1  clears overflow

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-high.
  - Outputs: evt_valid=0, evt_code=0, evt_break=0, evt_ext=0, fifo_count=0, overflow=0.
  - Internal: FSM=IDLE, FIFO empty, timeout counter=0, E1 skip counter=0.
  - Reset asserted mid-sequence or with a non-empty FIFO discards everything. No event is produced for a partial sequence.
- FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0), SKIP (E1 pause sequence). Transitions happen only on rx_valid cycles, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP with skip counter=7.
  - FA, AA, EE, FE, 00, FF -> dropped, stay IDLE.
  - Any other byte: push {code, break=0, ext=0}, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Other byte: push {code, 0, 1}, go to IDLE.
- BRK: any byte except E0/F0 -> push {code, 1, 0}, go to IDLE. E0 or F0 -> go to IDLE, no push (malformed sequence).
- EXT_BRK: any byte except E0/F0 -> push {code, 1, 1}, go to IDLE. E0 or F0 -> go to IDLE, no push.
- SKIP: each rx_valid decrements the skip counter. When the counter reaches 0 -> push {code=8'h77, 0, 1} (pause key), go to IDLE.
- Timeout:
  - In EXT, BRK, EXT_BRK and SKIP, the counter increments every cycle without rx_valid and clears on rx_valid.
  - When the counter equals TIMEOUT_CYCLES-1 -> go to IDLE, no push, counter=0.
  - rx_valid in the same cycle as timeout takes priority: the byte is processed in the current state.
- Latency: rx_valid on the final byte at cycle N -> entry written at edge N+1. With the FIFO previously empty, evt_valid=1 and fields valid from cycle N+1. Outputs are registered from FIFO storage (show-ahead).
- Handshake:
  - Pop occurs on a cycle with evt_valid & evt_ready.
  - evt_code/evt_break/evt_ext stay stable while evt_valid=1 and evt_ready=0.
  - evt_ready while empty is ignored.
- Full: a push with fifo_count==FIFO_DEPTH and no pop that cycle is dropped and sets overflow=1. Push and pop in the same cycle while full -> both occur, count unchanged.
- Empty: push and pop in the same empty cycle -> only the push occurs (nothing to pop).
- fifo_count: push-only +1, pop-only -1, both 0.
- Pointers wrap modulo FIFO_DEPTH.
- overflow: overflow_clr clears it. If overflow_clr and a new drop occur in the same cycle, the set wins.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Keeps a 256-bit key-down bitmap indexed by {ext, code[6:0]}.
  - A make event for a key whose bit is already 1 is not pushed (typematic repeat suppressed).
  - A make event sets the bit; a break event clears it and is always pushed.
  - Reset clears the bitmap.
  - The pause key is never filtered and never stored.
- Undefined: no bitmap exists and every make event (including repeats) is pushed.

Test Plan:
- Byte 1C, evt_ready=1 -> exactly one event {1C, break 0, ext 0}. evt_valid high for 1 cycle starting at N+1.
- Bytes E0 F0 75 -> one event {75, break 1, ext 1}. Bytes F0 1C -> {1C, 1, 0}. FA and AA alone -> no event.
- Byte E0, then 60000 idle cycles, then byte 1C -> E0 discarded by timeout. Single event {1C, 0, 0}.
- evt_ready=0, push 9 make codes with FIFO_DEPTH=8 -> fifo_count=8, overflow=1, head is the first code. Draining yields codes 1-8 in order. Then overflow_clr -> overflow=0.
- E1 14 77 E1 F0 14 F0 77 -> single event {77, 0, 1}. Reset asserted after E0 -> subsequent F0 1C yields {1C, 1, 0}.
- With PS2_TYPEMATIC_FILTER_EN, bytes 1C 1C 1C F0 1C -> two events: {1C, 0, 0} and {1C, 1, 0}. Without the macro -> four events.
